// File: rtl/output_serial_tx_pkg.sv
// Shared types and constants for the output-register serial transmitter.
// Build option: OUTPUT_PARITY_EN adds an even-parity bit to every byte frame.
package output_serial_tx_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } tx_state_t;

`ifdef OUTPUT_PARITY_EN
   localparam int FRAME_BITS = 11;
`else
   localparam int FRAME_BITS = 10;
`endif

   localparam int DEFAULT_CLKS_PER_BIT = 16;

   function automatic logic even_parity(input logic [7:0] value);
      return ^value;
   endfunction

endpackage

// File: rtl/output_serial_tx_if.sv
// Push-side bus between the CPU output register and the serial transmitter.
interface output_serial_tx_if #(
   parameter int DATA_W = 16,
   parameter int DEPTH  = 4
) ();

   localparam int LVL_W = $clog2(DEPTH) + 1;

   logic [DATA_W-1:0] data_in;
   logic              write_en;
   logic              full;
   logic [LVL_W-1:0]  level;

   modport master (
      output data_in,
      output write_en,
      input  full,
      input  level
   );

   modport slave (
      input  data_in,
      input  write_en,
      output full,
      output level
   );

endinterface

// File: rtl/output_serial_tx_fifo.sv
// Word FIFO with registered occupancy/full flags and a sticky overflow flag.
module output_fifo #(
   parameter int DATA_W = 16,
   parameter int DEPTH  = 4
) (
   input  logic                     clock,
   input  logic                     reset_n,
   input  logic                     write_en,
   input  logic [DATA_W-1:0]        data_in,
   input  logic                     pop,
   output logic [DATA_W-1:0]        head,
   output logic                     full,
   output logic                     empty,
   output logic                     overflow,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int LVL_W = PTR_W + 1;

   logic [DATA_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [LVL_W-1:0]  level_next;
   logic              do_push;
   logic              do_pop;

   // A write into a full FIFO is dropped even if a pop happens on the same edge.
   assign do_push = write_en && !full;
   assign do_pop  = pop && !empty;
   assign empty   = (level == '0);
   assign head    = mem[rd_ptr];

   always_comb begin
      level_next = level;
      case ({do_push, do_pop})
         2'b10:   level_next = level + LVL_W'(1);
         2'b01:   level_next = level - LVL_W'(1);
         default: level_next = level;
      endcase
   end

   always_ff @(posedge clock) begin
      if (do_push) begin
         mem[wr_ptr] <= data_in;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         level    <= '0;
         full     <= 1'b0;
         overflow <= 1'b0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         level <= level_next;
         full  <= (level_next == LVL_W'(DEPTH));
         if (write_en && full) begin
            overflow <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/output_serial_tx.sv
// Buffers output-register words and sends each as two UART byte frames, high byte first.
// Build option: OUTPUT_PARITY_EN inserts an even-parity bit between data and stop.
module output_serial_tx
   import output_serial_tx_pkg::*;
#(
   parameter int DATA_W       = 16,
   parameter int DEPTH        = 4,
   parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
   input  logic                clock,
   input  logic                reset_n,
   output_serial_tx_if.slave   bus,
   output logic                busy,
   output logic                overflow,
   output logic                tx
);

   localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

   tx_state_t         state;
   logic [BAUD_W-1:0] baud_cnt;
   logic [2:0]        bit_cnt;
   logic [DATA_W-1:0] word_reg;
   logic              low_sel;
   logic [7:0]        cur_byte;
   logic [DATA_W-1:0] head;
   logic              empty;
   logic              pop;
   logic              baud_end;

   output_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_fifo (
      .clock    (clock),
      .reset_n  (reset_n),
      .write_en (bus.write_en),
      .data_in  (bus.data_in),
      .pop      (pop),
      .head     (head),
      .full     (bus.full),
      .empty    (empty),
      .overflow (overflow),
      .level    (bus.level)
   );

   assign baud_end = (baud_cnt == BAUD_W'(CLKS_PER_BIT - 1));
   assign cur_byte = low_sel ? word_reg[7:0] : word_reg[DATA_W-1 -: 8];
   assign busy     = (state != IDLE) || !empty;

   // Words leave the FIFO when idle or at the end of a low-byte stop bit.
   assign pop = !empty && ((state == IDLE) || (state == STOP && baud_end && low_sel));

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state    <= IDLE;
         tx       <= 1'b1;
         baud_cnt <= '0;
         bit_cnt  <= '0;
         word_reg <= '0;
         low_sel  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               baud_cnt <= '0;
               if (!empty) begin
                  word_reg <= head;
                  low_sel  <= 1'b0;
                  tx       <= 1'b0;
                  state    <= START;
               end
            end
            START: begin
               if (baud_end) begin
                  baud_cnt <= '0;
                  bit_cnt  <= '0;
                  tx       <= cur_byte[0];
                  state    <= DATA;
               end else begin
                  baud_cnt <= baud_cnt + BAUD_W'(1);
               end
            end
            DATA: begin
               if (baud_end) begin
                  baud_cnt <= '0;
                  if (bit_cnt == 3'd7) begin
                     bit_cnt <= '0;
`ifdef OUTPUT_PARITY_EN
                     tx      <= even_parity(cur_byte);
                     state   <= PARITY;
`else
                     tx      <= 1'b1;
                     state   <= STOP;
`endif
                  end else begin
                     bit_cnt <= bit_cnt + 3'd1;
                     tx      <= cur_byte[bit_cnt + 3'd1];
                  end
               end else begin
                  baud_cnt <= baud_cnt + BAUD_W'(1);
               end
            end
            PARITY: begin
               if (baud_end) begin
                  baud_cnt <= '0;
                  tx       <= 1'b1;
                  state    <= STOP;
               end else begin
                  baud_cnt <= baud_cnt + BAUD_W'(1);
               end
            end
            STOP: begin
               if (baud_end) begin
                  baud_cnt <= '0;
                  if (!low_sel) begin
                     low_sel <= 1'b1;
                     tx      <= 1'b0;
                     state   <= START;
                  end else if (!empty) begin
                     word_reg <= head;
                     low_sel  <= 1'b0;
                     tx       <= 1'b0;
                     state    <= START;
                  end else begin
                     tx    <= 1'b1;
                     state <= IDLE;
                  end
               end else begin
                  baud_cnt <= baud_cnt + BAUD_W'(1);
               end
            end
            default: begin
               tx    <= 1'b1;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
